// File: rtl/idma_mp_midend_synth_pkg.sv
// Request/response payloads exchanged between the Mempool mid-end and an iDMA back-end.
package idma_mp_midend_synth_pkg;

   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [15:0] length;
   } idma_req_t;

   typedef struct packed {
      logic       error;
      logic [7:0] cause;
   } idma_rsp_t;

endpackage

// File: rtl/idma_pkg.sv
// Minimal iDMA back-end status types shared by the issue queue and its neighbours.
package idma_pkg;

   typedef struct packed {
      logic buffer_busy;
      logic r_dp_busy;
      logic w_dp_busy;
      logic r_leg_busy;
      logic w_leg_busy;
      logic eh_fsm_busy;
      logic eh_cnt_busy;
      logic raw_coupler_busy;
   } idma_busy_t;

endpackage

// File: rtl/idma_mp_be_issue_queue.sv
// Per-back-end issue stage: request FIFO, in-flight limiter and outstanding counter
// with a sticky flag for responses that arrive when nothing is in flight.
module idma_mp_be_issue_queue #(
   parameter int unsigned Depth          = 4,
   parameter int unsigned MaxOutstanding = 8,
   parameter type idma_req_t = idma_mp_midend_synth_pkg::idma_req_t,
   parameter type idma_rsp_t = idma_mp_midend_synth_pkg::idma_rsp_t
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  idma_req_t                            idma_req_i,
   input  logic                                 idma_req_valid_i,
   output logic                                 idma_req_ready_o,
   output idma_req_t                            idma_req_o,
   output logic                                 idma_req_valid_o,
   input  logic                                 idma_req_ready_i,
   input  idma_rsp_t                            idma_rsp_i,
   input  logic                                 idma_rsp_valid_i,
   output logic                                 idma_rsp_ready_o,
   output idma_rsp_t                            idma_rsp_o,
   output logic                                 idma_rsp_valid_o,
   input  logic                                 idma_rsp_ready_i,
   input  idma_pkg::idma_busy_t                 idma_busy_i,
   output idma_pkg::idma_busy_t                 idma_busy_o,
   output logic                                 idle_o,
   output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
   output logic                                 rsp_err_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

   idma_req_t       r_mem [Depth];
   logic [PtrW-1:0] r_rd_ptr;
   logic [PtrW-1:0] r_wr_ptr;
   logic [CntW-1:0] r_count;
   logic [OutW-1:0] r_outstanding;
   logic            r_rsp_err;

   logic w_push;
   logic w_pop;
   logic w_rsp;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign idma_req_ready_o = (r_count != CntW'(Depth));
   assign idma_req_valid_o = (r_count != '0) && (r_outstanding < OutW'(MaxOutstanding));
   assign idma_req_o       = r_mem[r_rd_ptr];

   assign w_push = idma_req_valid_i && idma_req_ready_o;
   assign w_pop  = idma_req_valid_o && idma_req_ready_i;
   assign w_rsp  = idma_rsp_valid_i && idma_rsp_ready_i;

   assign idma_rsp_o       = idma_rsp_i;
   assign idma_rsp_valid_o = idma_rsp_valid_i;
   assign idma_rsp_ready_o = idma_rsp_ready_i;
   assign idma_busy_o      = idma_busy_i;

   assign idle_o        = (r_count == '0) && (r_outstanding == '0) && (idma_busy_i == '0);
   assign outstanding_o = r_outstanding;
   assign rsp_err_o     = r_rsp_err;

   // Payload storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= idma_req_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CntW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CntW'(1);
         end
      end
   end

   // A response with nothing in flight leaves the counter at zero and latches the error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_outstanding <= '0;
         r_rsp_err     <= 1'b0;
      end else begin
         if (w_pop && !w_rsp) begin
            r_outstanding <= r_outstanding + OutW'(1);
         end else if (w_rsp && !w_pop && (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - OutW'(1);
         end
         if (w_rsp && (r_outstanding == '0)) begin
            r_rsp_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_idma_mp_be_issue_queue.sv
// Self-checking bench: two issue queues (Depth 4/Max 2 and Depth 3/Max 8) share stimulus
// and are compared every cycle against a queue-based reference model plus directed checks.
module tb_idma_mp_be_issue_queue;
   import idma_mp_midend_synth_pkg::*;
   import idma_pkg::idma_busy_t;

   localparam int unsigned DA = 4;
   localparam int unsigned MA = 2;
   localparam int unsigned DB = 3;
   localparam int unsigned MB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   idma_req_t  req_i;
   logic       req_vi, req_ri;
   idma_rsp_t  rsp_i;
   logic       rsp_vi, rsp_ri;
   idma_busy_t busy_i;

   logic       a_rdy, a_vld, a_rspr, a_rspv, a_err, a_idle;
   idma_req_t  a_req;
   idma_rsp_t  a_rsp;
   idma_busy_t a_busy;
   logic [1:0] a_out;

   logic       b_rdy, b_vld, b_rspr, b_rspv, b_err, b_idle;
   idma_req_t  b_req;
   idma_rsp_t  b_rsp;
   idma_busy_t b_busy;
   logic [3:0] b_out;

   idma_mp_be_issue_queue #(.Depth(DA), .MaxOutstanding(MA)) u_dut_a (
      .clk_i(clk), .rst_i(rst),
      .idma_req_i(req_i), .idma_req_valid_i(req_vi), .idma_req_ready_o(a_rdy),
      .idma_req_o(a_req), .idma_req_valid_o(a_vld), .idma_req_ready_i(req_ri),
      .idma_rsp_i(rsp_i), .idma_rsp_valid_i(rsp_vi), .idma_rsp_ready_o(a_rspr),
      .idma_rsp_o(a_rsp), .idma_rsp_valid_o(a_rspv), .idma_rsp_ready_i(rsp_ri),
      .idma_busy_i(busy_i), .idma_busy_o(a_busy), .idle_o(a_idle),
      .outstanding_o(a_out), .rsp_err_o(a_err)
   );

   idma_mp_be_issue_queue #(.Depth(DB), .MaxOutstanding(MB)) u_dut_b (
      .clk_i(clk), .rst_i(rst),
      .idma_req_i(req_i), .idma_req_valid_i(req_vi), .idma_req_ready_o(b_rdy),
      .idma_req_o(b_req), .idma_req_valid_o(b_vld), .idma_req_ready_i(req_ri),
      .idma_rsp_i(rsp_i), .idma_rsp_valid_i(rsp_vi), .idma_rsp_ready_o(b_rspr),
      .idma_rsp_o(b_rsp), .idma_rsp_valid_o(b_rspv), .idma_rsp_ready_i(rsp_ri),
      .idma_busy_i(busy_i), .idma_busy_o(b_busy), .idle_o(b_idle),
      .outstanding_o(b_out), .rsp_err_o(b_err)
   );

   // Reference model: contents of each queue in arrival order plus in-flight count.
   idma_req_t mq [2][$];
   int        m_out [2];
   bit        m_err [2];
   int        dep [2];
   int        mo [2];
   idma_req_t obs_a [$];
   idma_req_t obs_b [$];
   bit        chk_en;
   int        checks = 0;
   int        errors = 0;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic idma_req_t rand_req();
      idma_req_t r;
      r.src_addr = $urandom;
      r.dst_addr = $urandom;
      r.length   = 16'($urandom);
      return r;
   endfunction

   task automatic check_inst(input int i, input logic rdy, input logic vld, input idma_req_t req,
                             input int outs, input logic err, input logic idle, input idma_rsp_t rsp,
                             input logic rv, input logic rr, input idma_busy_t bo);
      string p;
      bit    exp_vld;
      p       = (i == 0) ? "A" : "B";
      exp_vld = (mq[i].size() != 0) && (m_out[i] < mo[i]);
      chk({p, ".req_ready"}, 80'(rdy), 80'(mq[i].size() != dep[i]));
      chk({p, ".req_valid"}, 80'(vld), 80'(exp_vld));
      if (exp_vld) chk({p, ".req_data"}, 80'(req), 80'(mq[i][0]));
      chk({p, ".outstanding"}, 80'(outs), 80'(m_out[i]));
      chk({p, ".rsp_err"}, 80'(err), 80'(m_err[i]));
      chk({p, ".idle"}, 80'(idle), 80'((mq[i].size() == 0) && (m_out[i] == 0) && (busy_i == '0)));
      chk({p, ".rsp_data"}, 80'(rsp), 80'(rsp_i));
      chk({p, ".rsp_valid"}, 80'(rv), 80'(rsp_vi));
      chk({p, ".rsp_ready"}, 80'(rr), 80'(rsp_ri));
      chk({p, ".busy"}, 80'(bo), 80'(busy_i));
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit push, pop, rsp;
         push = req_vi && (mq[i].size() != dep[i]);
         pop  = req_ri && (mq[i].size() != 0) && (m_out[i] < mo[i]);
         rsp  = rsp_vi && rsp_ri;
         if (rst) begin
            mq[i].delete();
            m_out[i] = 0;
            m_err[i] = 1'b0;
         end else begin
            if (rsp && m_out[i] == 0) m_err[i] = 1'b1;
            if (pop && !rsp) m_out[i] = m_out[i] + 1;
            else if (rsp && !pop && m_out[i] > 0) m_out[i] = m_out[i] - 1;
            if (pop) void'(mq[i].pop_front());
            if (push) mq[i].push_back(req_i);
         end
      end
   endtask

   // Inputs are set at the falling edge; outputs are sampled 1 time unit later.
   task automatic cycle();
      #1;
      if (chk_en) begin
         check_inst(0, a_rdy, a_vld, a_req, int'(a_out), a_err, a_idle, a_rsp, a_rspv, a_rspr, a_busy);
         check_inst(1, b_rdy, b_vld, b_req, int'(b_out), b_err, b_idle, b_rsp, b_rspv, b_rspr, b_busy);
      end
      if (a_vld && req_ri) obs_a.push_back(a_req);
      if (b_vld && req_ri) obs_b.push_back(b_req);
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_vi = 1'b0;
      req_ri = 1'b0;
      rsp_vi = 1'b0;
      rsp_ri = 1'b0;
      busy_i = '0;
      req_i  = rand_req();
      rsp_i  = idma_rsp_t'(9'($urandom));
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   idma_req_t d [10];
   int        n;
   bit        acc;

   initial begin
      dep    = '{DA, DB};
      mo     = '{MA, MB};
      m_out  = '{0, 0};
      m_err  = '{1'b0, 1'b0};
      chk_en = 1'b0;
      rst    = 1'b1;
      idle_inputs();
      @(negedge clk);

      // Reset defaults with random inputs held during reset.
      for (int c = 0; c < 2; c++) begin
         req_vi = 1'($urandom); req_ri = 1'($urandom); rsp_vi = 1'($urandom);
         rsp_ri = 1'($urandom); busy_i = idma_busy_t'(8'($urandom)); req_i = rand_req();
         cycle();
         chk_en = 1'b1;
      end
      rst = 1'b0;
      idle_inputs();
      cycle();
      chk("rst.a_ready", 80'(a_rdy), 80'(1)); chk("rst.a_valid", 80'(a_vld), 80'(0));
      chk("rst.a_out", 80'(a_out), 80'(0));   chk("rst.a_err", 80'(a_err), 80'(0));
      chk("rst.a_idle", 80'(a_idle), 80'(1)); chk("rst.b_ready", 80'(b_rdy), 80'(1));
      chk("rst.b_idle", 80'(b_idle), 80'(1));

      // Full FIFO on A, then release in order.
      for (int k = 0; k < 6; k++) d[k] = rand_req();
      obs_a.delete();
      for (int k = 0; k < 6; k++) begin
         req_vi = 1'b1; req_i = d[k];
         cycle();
         if (k == 3) chk("full.ready_low", 80'(a_rdy), 80'(0));
      end
      req_vi = 1'b0; req_ri = 1'b1;
      cycle();
      chk("full.ready_back", 80'(a_rdy), 80'(1));
      rsp_vi = 1'b1; rsp_ri = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (k == 0) chk("simul.out_hold", 80'(a_out), 80'(1));
      end
      chk("full.issued", 80'(obs_a.size()), 80'(4));
      for (int k = 0; k < 4; k++) if (k < obs_a.size()) chk("full.order", 80'(obs_a[k]), 80'(d[k]));
      do_reset();

      // Outstanding cap on A.
      obs_a.delete();
      req_ri = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d[k] = rand_req(); req_vi = 1'b1; req_i = d[k];
         cycle();
      end
      req_vi = 1'b0;
      repeat (4) cycle();
      chk("cap.out", 80'(a_out), 80'(2));
      chk("cap.valid", 80'(a_vld), 80'(0));
      chk("cap.issued", 80'(obs_a.size()), 80'(2));
      rsp_vi = 1'b1; rsp_ri = 1'b1;
      cycle();
      rsp_vi = 1'b0;
      chk("cap.valid_again", 80'(a_vld), 80'(1));
      cycle();
      chk("cap.out_after", 80'(a_out), 80'(2));
      chk("cap.third", 80'(obs_a.size()), 80'(3));
      if (obs_a.size() > 2) chk("cap.third_data", 80'(obs_a[2]), 80'(d[2]));
      do_reset();

      // Pointer wrap on B: 10 transfers through a 3-deep FIFO with push+pop at count 2.
      for (int k = 0; k < 10; k++) d[k] = rand_req();
      obs_b.delete();
      n = 0;
      for (int c = 0; c < 40; c++) begin
         req_vi = (n < 10);
         req_i  = d[(n < 10) ? n : 9];
         req_ri = (c >= 2);
         rsp_ri = 1'b1;
         rsp_vi = (m_out[1] > 0);
         acc    = req_vi && b_rdy;
         cycle();
         if (acc) n++;
      end
      chk("wrap.accepted", 80'(n), 80'(10));
      chk("wrap.issued", 80'(obs_b.size()), 80'(10));
      for (int k = 0; k < 10; k++) if (k < obs_b.size()) chk("wrap.order", 80'(obs_b[k]), 80'(d[k]));
      do_reset();

      // Spurious response.
      rsp_vi = 1'b1; rsp_ri = 1'b1;
      cycle();
      rsp_vi = 1'b0;
      chk("spur.a_err", 80'(a_err), 80'(1));
      chk("spur.b_err", 80'(b_err), 80'(1));
      chk("spur.a_out", 80'(a_out), 80'(0));
      repeat (3) cycle();
      chk("spur.sticky", 80'(a_err), 80'(1));
      do_reset();
      chk("spur.cleared", 80'(a_err), 80'(0));

      // Busy blocks idle.
      busy_i = idma_busy_t'(8'(1) << $urandom_range(7));
      #1;
      chk("busy.a_idle", 80'(a_idle), 80'(0));
      chk("busy.b_idle", 80'(b_idle), 80'(0));
      cycle();
      busy_i = '0;

      // Reset with 3 queued and 2 outstanding on A.
      req_ri = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req_vi = 1'b1; req_i = rand_req();
         cycle();
      end
      req_vi = 1'b0;
      repeat (2) cycle();
      chk("midrst.pre_out", 80'(a_out), 80'(2));
      chk("midrst.pre_valid", 80'(a_vld), 80'(0));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst.out", 80'(a_out), 80'(0));
      chk("midrst.ready", 80'(a_rdy), 80'(1));
      chk("midrst.idle", 80'(a_idle), 80'(1));
      chk("midrst.b_out", 80'(b_out), 80'(0));
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("midrst.no_stale", 80'(a_vld), 80'(0));
      end

      // Random traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         rst    = ($urandom_range(199) == 0);
         req_vi = ($urandom_range(3) != 0);
         req_i  = rand_req();
         req_ri = ($urandom_range(2) != 0);
         rsp_vi = ($urandom_range(2) == 0);
         rsp_ri = ($urandom_range(3) != 0);
         rsp_i  = idma_rsp_t'(9'($urandom));
         busy_i = ($urandom_range(7) == 0) ? idma_busy_t'(8'($urandom)) : '0;
         cycle();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
